multdiv_ctrl: RTL
=================

# multdiv_ctrl

Sequencer for the multiply/divide unit. It accepts one signed 32-bit multiply or divide command at a time. It runs a 32-iteration shift-add multiply or a restoring divide, and it performs every iterative add/subtract through one external 32-bit carry-lookahead adder built from four 8-bit CLA blocks. It returns a 32-bit result with an exception flag and a one-cycle ready pulse.

## Interface
- No parameters. Width is fixed at 32 bits.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ctrl_MULT  in  1  start multiply; sampled only in IDLE
- ctrl_DIV  in  1  start divide; sampled only in IDLE
- data_operandA  in  32  multiplicand or dividend (two's complement); captured at start
- data_operandB  in  32  multiplier or divisor (two's complement); captured at start
- data_result  out  32  result; holds until the next completion
- data_exception  out  1  overflow or divide-by-zero; updates with data_result
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- add_a  out  32  shared adder operand A
- add_b  out  32  shared adder operand B
- add_cin  out  1  shared adder carry-in
- add_sum  in  32  adder sum, combinational from add_a/add_b/add_cin in the same cycle
- add_cout  in  1  adder carry-out

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - ctrl_MULT=1 starts a multiply. If ctrl_MULT and ctrl_DIV are both 1, multiply wins.
  - On start: capture the operands and latch op type and result sign (signA XOR signB). Next state is PREP.
- PREP:
  - Convert the operands to unsigned magnitudes with internal negation. 0x80000000 becomes 2^31.
  - Clear the iteration counter (5 bits) and the hi/remainder register. Next state is RUN.
  - Divide with operandB=0: go straight to DONE with result 0 and exception 1.
- RUN, multiply (lo = multiplier magnitude, M = multiplicand magnitude), 32 iterations:
  - If lo[0]=1: add_a=hi, add_b=M, add_cin=0. Otherwise add_a=hi, add_b=0, add_cin=0.
  - Then shift right: {hi,lo} <= {add_cout, add_sum, lo[31:1]}.
- RUN, divide (q = dividend magnitude, D = divisor magnitude), 32 iterations:
  - Shift: R' = {R[30:0], q[31]}. Drive add_a=R', add_b=~D, add_cin=1.
  - If add_cout=1: R <= add_sum and the new q bit is 1. Otherwise R <= R' and the new q bit is 0.
  - q shifts left each iteration.
- FIX:
  - Apply the sign: negate the 64-bit product or the 32-bit quotient when the result sign is 1. Quotient truncates toward zero; the remainder is discarded.
  - Multiply overflow: the signed 64-bit product is outside [-2^31, 2^31-1]. data_result is the low 32 bits and exception=1.
  - Divide overflow: 0x80000000 / -1. Result is 0x80000000 and exception=1.
- DONE: data_resultRDY=1 for one cycle, then go to IDLE.
- Adder ports are 0 in IDLE, PREP, FIX and DONE. The adder is used only in RUN.
- ctrl_MULT/ctrl_DIV are ignored while busy=1. No queueing.

## Timing
- Start sampled at edge E0. PREP follows E0; RUN covers E1..E33 (32 cycles); FIX follows E33; DONE follows E34.
- data_resultRDY is high for exactly the cycle after E34. data_result and data_exception update on E34.
- Divide by zero: DONE follows E1, so data_resultRDY is high for the cycle after E1.
- A new start is accepted at the first edge in IDLE, i.e. two edges after the ready pulse begins.
- Reset (asynchronous, any state, including mid-RUN):
  - State goes to IDLE; the counter and all internal registers clear.
  - Outputs: data_result=0, data_exception=0, data_resultRDY=0, busy=0, add_a=0, add_b=0, add_cin=0.
- The counter wraps from 31 to 0 on the RUN→FIX transition; RUN never runs a 33rd iteration.
- All outputs are registered except the add_* ports, which are decoded from state and registers.

## Test plan
- **Multiply basic:** 7 × -6, ctrl_MULT at E0 → data_resultRDY in the cycle after E34, result 0xFFFFFFD6, exception 0. The bench adder model checks 32 RUN cycles with nonzero add_b only when lo[0]=1.
- **Multiply overflow and edge case:**
  - 0x00010000 × 0x00010000 → result 0x00000000, exception 1.
  - 0x80000000 × 1 → result 0x80000000, exception 0.
  - -1 × -1 → result 1, exception 0.
- **Divide signed:**
  - -100 / 7 → result 0xFFFFFFF2 (-14), exception 0.
  - 100 / -7 → 0xFFFFFFF2.
  - 3 / 5 → 0.
- **Divide exceptions:**
  - 5 / 0 → ready in the cycle after E1, result 0, exception 1.
  - 0x80000000 / -1 → ready after E34, result 0x80000000, exception 1.
- **Protocol:**
  - ctrl_MULT and ctrl_DIV together with 6 and 3 → multiply, result 18.
  - ctrl_DIV pulsed at E10 of a running multiply → ignored; exactly one ready pulse; the multiply result is unchanged.
- **Reset mid-operation:**
  - reset_n low at E12 of a divide → all outputs 0 immediately.
  - After release, 9 × 9 completes with result 81, exception 0, with the ready pulse after E34 of the new start.

Source files
------------

// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: command/result bus and shared adder bus; slave = sequencer, master = requester plus adder
interface multdiv_ctrl_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, add_sum, add_cout,
    output data_result, data_exception, data_resultRDY, busy, add_a, add_b, add_cin
  );
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, add_sum, add_cout,
    input  data_result, data_exception, data_resultRDY, busy, add_a, add_b, add_cin
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: signed 32-bit shift-add multiply / restoring divide sequencer; clock, reset_n (async low), bus = commands, results and shared adder
module multdiv_ctrl (
  input logic           clock,
  input logic           reset_n,
  multdiv_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
  state_t      state_q;
  logic        div_q, sign_q, exc_q, rdy_q, busy_q;
  logic [31:0] hi_q, lo_q, m_q, result_q;
  logic [4:0]  cnt_q;
  logic [31:0] rs, quo;
  logic [63:0] prod;
  logic        run;
  assign run  = state_q == RUN;
  assign rs   = {hi_q[30:0], lo_q[31]};
  assign prod = sign_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quo  = sign_q ? -lo_q : lo_q;
  assign bus.add_a          = !run ? '0 : div_q ? rs : hi_q;
  assign bus.add_b          = !run ? '0 : div_q ? ~m_q : lo_q[0] ? m_q : '0;
  assign bus.add_cin        = run && div_q;
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      div_q    <= 1'b0;
      sign_q   <= 1'b0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.ctrl_MULT || bus.ctrl_DIV) begin
          state_q <= PREP;
          busy_q  <= 1'b1;
          div_q   <= !bus.ctrl_MULT;
          sign_q  <= bus.data_operandA[31] ^ bus.data_operandB[31];
          lo_q    <= bus.ctrl_MULT ? bus.data_operandB : bus.data_operandA;
          m_q     <= bus.ctrl_MULT ? bus.data_operandA : bus.data_operandB;
        end
        PREP: begin
          hi_q  <= '0;
          cnt_q <= '0;
          lo_q  <= lo_q[31] ? -lo_q : lo_q;
          m_q   <= m_q[31] ? -m_q : m_q;
          if (div_q && m_q == '0) begin
            state_q  <= DONE;
            result_q <= '0;
            exc_q    <= 1'b1;
            rdy_q    <= 1'b1;
          end else state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
          if (div_q) begin
            hi_q <= bus.add_cout ? bus.add_sum : rs;
            lo_q <= {lo_q[30:0], bus.add_cout};
          end else {hi_q, lo_q} <= {bus.add_cout, bus.add_sum, lo_q[31:1]};
        end
        FIX: begin
          state_q  <= DONE;
          rdy_q    <= 1'b1;
          result_q <= div_q ? quo : prod[31:0];
          exc_q    <= div_q ? (!sign_q && lo_q[31]) : !(&prod[63:31] || ~|prod[63:31]);
        end
        DONE: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
